counter_display_ctrl: RTL and testbench

Sequencing controller for the two-digit counter display path. It owns the 6-bit value fed to `binaryToBCD` and runs that value as an up/down counter under start/pause/load control with a prescaled step. It also time-multiplexes one shared `sevenSegmentsDeco` between the units and tens digits. It sits between the board buttons/switches and the BCD-to-segment datapath.

---
 rtl/counter_display_ctrl.sv | 126 ++++++++++++
 tb/tb_counter_display_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/counter_display_ctrl.sv
// Run/pause/load up-down counter with prescaled step and two-digit display scanner.
// Optional build macro CNT_WRAP_EN: counter wraps at 0/63 instead of stopping in DONE.
module counter_display_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       dir,
    output logic [5:0] count,
    input  logic [7:0] bcd,
    output logic [3:0] digit_bcd,
    output logic [1:0] digit_en,
    output logic       running,
    output logic       done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [5:0]    r_count, w_count_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [5:0]    w_step_val;
    logic [SW-1:0] r_scan_cnt;
    logic          r_digit_idx;

`ifndef CNT_WRAP_EN
    function automatic logic f_term(input logic [5:0] v, input logic d);
        return d ? (v == 6'd63) : (v == 6'd0);
    endfunction
`endif

    assign w_step_val = dir ? (r_count + 6'd1) : (r_count - 6'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    // load overrides everything; a start in the same cycle is dropped
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        if (load) begin
            w_count_nxt = load_val;
            w_presc_nxt = '0;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
`ifdef CNT_WRAP_EN
                        w_state_nxt = S_RUN;
`else
                        w_state_nxt = f_term(r_count, dir) ? S_DONE : S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    if (start) begin
                        w_state_nxt = S_PAUSE;
                    end else if (r_presc == TICK_MAX) begin
                        w_presc_nxt = '0;
                        w_count_nxt = w_step_val;
`ifndef CNT_WRAP_EN
                        if (f_term(w_step_val, dir))
                            w_state_nxt = S_DONE;
`endif
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (start)
                        w_state_nxt = S_RUN;
                end
                default: ;
            endcase
        end
    end

    // Digit scanner runs independently of the counter FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= 1'b0;
        end else if (r_scan_cnt == SCAN_MAX) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= ~r_digit_idx;
        end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
        end
    end

    assign count     = r_count;
    assign running   = (r_state == S_RUN);
`ifdef CNT_WRAP_EN
    assign done      = 1'b0;
`else
    assign done      = (r_state == S_DONE);
`endif
    assign digit_bcd = r_digit_idx ? bcd[7:4] : bcd[3:0];
    assign digit_en  = !r_digit_idx ? 2'b01 : ((bcd[7:4] == 4'd0) ? 2'b00 : 2'b10);

endmodule

// File: tb/tb_counter_display_ctrl.sv
// Directed bench for counter_display_ctrl with TICK_DIV=4, SCAN_DIV=2 and a behavioural binary-to-BCD stage.
module tb_counter_display_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, load, dir;
    logic [5:0] load_val;
    logic [5:0] count;
    logic [7:0] bcd;
    logic [3:0] digit_bcd;
    logic [1:0] digit_en;
    logic       running, done;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    counter_display_ctrl #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load(load), .load_val(load_val),
        .dir(dir), .count(count), .bcd(bcd), .digit_bcd(digit_bcd),
        .digit_en(digit_en), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational binaryToBCD block
    always_comb bcd = {4'(count / 10), 4'(count % 10)};

    // Edges since reset release; scan index is (cyc / 2) % 2
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        bit         ld;
        logic [5:0] lv;
        bit         dr;
        bit         st;
        int         n;
        int         ec;
        bit         er;
        bit         ed;
    } vec_t;

    vec_t tbl[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string nm, input int ec, input bit er, input bit ed);
        n_vec++;
        if (count !== 6'(ec) || running !== er || done !== ed) begin
            n_err++;
            $display("FAIL %s: got count=%0d running=%0b done=%0b, want count=%0d running=%0b done=%0b",
                     nm, count, running, done, ec, er, ed);
        end
    endtask

    task automatic chk_dig(input string nm, input int ec);
        logic [3:0] eb;
        logic [1:0] ee;
        logic [3:0] tens;
        tens = 4'(ec / 10);
        if (((cyc / 2) % 2) == 0) begin
            eb = 4'(ec % 10);
            ee = 2'b01;
        end else begin
            eb = tens;
            ee = (tens == 4'd0) ? 2'b00 : 2'b10;
        end
        n_vec++;
        if (digit_bcd !== eb || digit_en !== ee) begin
            n_err++;
            $display("FAIL %s: got digit_bcd=%0d digit_en=%b, want digit_bcd=%0d digit_en=%b",
                     nm, digit_bcd, digit_en, eb, ee);
        end
    endtask

    task automatic pulse(input bit ld, input logic [5:0] lv, input bit st);
        load = ld; load_val = lv; start = st;
        tick(1);
        load = 1'b0; start = 1'b0;
    endtask

    initial begin
        logic [1:0] scan_exp [5];
        scan_exp = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01};

        rst_n = 1'b0; start = 1'b0; load = 1'b0; load_val = '0; dir = 1'b1;
        tick(3);
        chk_ctl("reset_state", 0, 0, 0);
        chk_dig("reset_digit", 0);

        // Scan pattern with tens blanked while count is 0
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (digit_en !== scan_exp[i] || digit_bcd !== 4'd0) begin
                n_err++;
                $display("FAIL scan_%0d: got digit_en=%b digit_bcd=%0d, want digit_en=%b digit_bcd=0",
                         i, digit_en, digit_bcd, scan_exp[i]);
            end
            tick(1);
        end

`ifndef CNT_WRAP_EN
        tbl.push_back('{1, 10, 1, 0, 1, 10, 0, 0});
        tbl.push_back('{0,  0, 1, 1, 1, 10, 1, 0});
        tbl.push_back('{0,  0, 1, 0, 3, 10, 1, 0});
        tbl.push_back('{0,  0, 1, 0, 1, 11, 1, 0});
        tbl.push_back('{0,  0, 1, 0, 4, 12, 1, 0});
        tbl.push_back('{1, 62, 1, 0, 1, 62, 0, 0});
        tbl.push_back('{0,  0, 1, 1, 1, 62, 1, 0});
        tbl.push_back('{0,  0, 1, 0, 4, 63, 0, 1});
        tbl.push_back('{0,  0, 1, 1, 1, 63, 0, 1});
        tbl.push_back('{0,  0, 1, 0, 5, 63, 0, 1});
        tbl.push_back('{1,  7, 0, 0, 1,  7, 0, 0});
        tbl.push_back('{0,  0, 0, 1, 1,  7, 1, 0});
        tbl.push_back('{0,  0, 0, 0, 27, 1, 1, 0});
        tbl.push_back('{0,  0, 0, 0, 1,  0, 0, 1});
        tbl.push_back('{1,  0, 0, 0, 1,  0, 0, 0});
        tbl.push_back('{0,  0, 0, 1, 1,  0, 0, 1});
        tbl.push_back('{1,  5, 1, 1, 1,  5, 0, 0});
`else
        tbl.push_back('{1, 63, 1, 0, 1, 63, 0, 0});
        tbl.push_back('{0,  0, 1, 1, 1, 63, 1, 0});
        tbl.push_back('{0,  0, 1, 0, 3, 63, 1, 0});
        tbl.push_back('{0,  0, 1, 0, 1,  0, 1, 0});
        tbl.push_back('{0,  0, 1, 0, 4,  1, 1, 0});
        tbl.push_back('{1,  0, 0, 0, 1,  0, 0, 0});
        tbl.push_back('{0,  0, 0, 1, 1,  0, 1, 0});
        tbl.push_back('{0,  0, 0, 0, 4, 63, 1, 0});
        tbl.push_back('{1,  5, 1, 1, 1,  5, 0, 0});
`endif

        foreach (tbl[i]) begin
            dir = tbl[i].dr;
            pulse(tbl[i].ld, tbl[i].lv, tbl[i].st);
            if (tbl[i].n > 1) tick(tbl[i].n - 1);
            chk_ctl($sformatf("vec%0d_ctl", i), tbl[i].ec, tbl[i].er, tbl[i].ed);
            chk_dig($sformatf("vec%0d_dig", i), tbl[i].ec);
        end

        // start coinciding with the step cycle: pause wins, prescaler holds
        dir = 1'b1;
        pulse(1'b1, 6'd20, 1'b0);
        pulse(1'b0, 6'd0, 1'b1);
        tick(3);
        chk_ctl("pre_collide", 20, 1, 0);
        pulse(1'b0, 6'd0, 1'b1);
        chk_ctl("collide_pause", 20, 0, 0);
        tick(2);
        chk_ctl("paused_hold", 20, 0, 0);
        pulse(1'b0, 6'd0, 1'b1);
        chk_ctl("resume", 20, 1, 0);
        tick(1);
        chk_ctl("resume_step", 21, 1, 0);
        chk_dig("resume_dig", 21);

        // Asynchronous reset in the middle of a run
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk_ctl("midrun_reset", 0, 0, 0);
        n_vec++;
        if (digit_en !== 2'b01) begin
            n_err++;
            $display("FAIL midrun_reset_en: got digit_en=%b, want 01", digit_en);
        end
        tick(1);
        rst_n = 1'b1;
        pulse(1'b0, 6'd0, 1'b1);
        chk_ctl("post_reset_start", 0, 1, 0);
        tick(4);
        chk_ctl("post_reset_step", 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
